// File: rtl/uart_bus_master.sv
// UART debug bridge: 'W' addr[4] data[4] / 'R' addr[4] commands become single bus transactions.
// Optional bus and inter-byte timeouts are enabled by defining UART_BUS_MASTER_TIMEOUT_EN.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        baudclk16,
    input  logic        rxd,
    output logic        txd,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_UN = 8'h3F;

    // ---------------- receiver ----------------
    logic [1:0] rx_sync;
    rx_state_t  rx_state;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh;
    logic       rx_valid;
    logic       rx_ferr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_state <= RX_IDLE;
            rx_cnt   <= 4'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'd0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (baudclk16) begin
                rx_cnt <= rx_cnt + 4'd1;
                case (rx_state)
                    RX_IDLE: begin
                        rx_cnt <= 4'd0;
                        if (!rx_sync[1]) rx_state <= RX_START;
                    end
                    RX_START: begin
                        // Mid-start re-check filters glitches on the line.
                        if (rx_cnt == 4'd7) begin
                            rx_cnt   <= 4'd0;
                            rx_bit   <= 3'd0;
                            rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (rx_cnt == 4'd15) begin
                            rx_sh  <= {rx_sync[1], rx_sh[7:1]};
                            rx_bit <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        end
                    end
                    default: begin
                        if (rx_cnt == 4'd15) begin
                            rx_state <= RX_IDLE;
                            rx_valid <= rx_sync[1];
                            rx_ferr  <= !rx_sync[1];
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- parser ----------------
    state_t      state, next_state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_sh;
    logic [31:0] resp_sh;
    logic [2:0]  resp_left;
    logic        bus_timeout;
    logic        ib_timeout;
    logic        tx_active;
    logic [3:0]  tx_cnt;
    logic [3:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_last;
    logic        tx_start;

    assign mem_addr = {addr_sh[31:2], 2'b00};
    assign tx_last  = tx_active && (tx_cnt == 4'd15) && (tx_bit == 4'd9);
    // A new byte may start on the very tick that ends the previous stop bit.
    assign tx_start = baudclk16 && (state == RESP) && (resp_left != 3'd0) && (!tx_active || tx_last);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] bus_cnt;
    logic [11:0]     ib_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_cnt <= '0;
            ib_cnt  <= 12'd0;
        end else begin
            bus_cnt <= (state == BUS) ? bus_cnt + TO_W'(1) : '0;
            if (!(state == ADDR || state == DATA) || rx_valid) ib_cnt <= 12'd0;
            else if (baudclk16) ib_cnt <= ib_cnt + 12'd1;
        end
    end

    assign bus_timeout = (state == BUS) && (bus_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign ib_timeout  = baudclk16 && (ib_cnt == 12'hFFF) && (state == ADDR || state == DATA);
`else
    assign bus_timeout = 1'b0;
    assign ib_timeout  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets its default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (rx_valid) next_state = (rx_sh == CMD_W || rx_sh == CMD_R) ? ADDR : RESP;
            ADDR: begin
                if (rx_ferr || ib_timeout)               next_state = IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   next_state = is_write ? DATA : BUS;
            end
            DATA: begin
                if (rx_ferr || ib_timeout)               next_state = IDLE;
                else if (rx_valid && byte_cnt == 2'd3)   next_state = BUS;
            end
            BUS:  if ((mem_valid && mem_ready) || bus_timeout) next_state = RESP;
            RESP: if (resp_left == 3'd0 && baudclk16 && tx_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            addr_sh   <= 32'd0;
            mem_wdata <= 32'd0;
            resp_sh   <= 32'd0;
            resp_left <= 3'd0;
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            busy      <= 1'b0;
        end else begin
            mem_valid <= (next_state == BUS);
            mem_wstrb <= (next_state == BUS && is_write) ? 4'hF : 4'h0;
            busy      <= (next_state != IDLE);
            case (state)
                IDLE: if (rx_valid) begin
                    is_write  <= (rx_sh == CMD_W);
                    byte_cnt  <= 2'd0;
                    resp_sh   <= {RSP_UN, 24'd0};
                    resp_left <= 3'd1;
                end
                ADDR: if (rx_valid) begin
                    addr_sh  <= {addr_sh[23:0], rx_sh};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                DATA: if (rx_valid) begin
                    mem_wdata <= {mem_wdata[23:0], rx_sh};
                    byte_cnt  <= byte_cnt + 2'd1;
                end
                BUS: begin
                    if (mem_valid && mem_ready) begin
                        resp_sh   <= is_write ? {RSP_OK, 24'd0} : mem_rdata;
                        resp_left <= is_write ? 3'd1 : 3'd4;
                    end else if (bus_timeout) begin
                        resp_sh   <= {8'h54, 24'd0};
                        resp_left <= 3'd1;
                    end
                end
                RESP: if (tx_start) begin
                    resp_sh   <= {resp_sh[23:0], 8'd0};
                    resp_left <= resp_left - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd       <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= 4'd0;
            tx_bit    <= 4'd0;
            tx_sh     <= 8'd0;
        end else if (tx_start) begin
            txd       <= 1'b0;
            tx_active <= 1'b1;
            tx_cnt    <= 4'd0;
            tx_bit    <= 4'd0;
            tx_sh     <= resp_sh[31:24];
        end else if (baudclk16 && tx_active) begin
            tx_cnt <= tx_cnt + 4'd1;
            if (tx_cnt == 4'd15) begin
                tx_bit <= tx_bit + 4'd1;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    txd       <= 1'b1;
                end else if (tx_bit == 4'd8) begin
                    txd <= 1'b1;
                end else begin
                    txd   <= tx_sh[0];
                    tx_sh <= {1'b0, tx_sh[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: command table, bus responder and UART response scoreboards.
module tb_uart_bus_master;
    logic        clk;
    logic        reset;
    logic        baudclk16;
    logic        rxd;
    logic        txd;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .baudclk16(baudclk16), .rxd(rxd), .txd(txd),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic [71:0] cmd;     // command bytes, left aligned
        int          ncmd;
        int          delay;   // ready asserted after this many valid cycles
        logic [31:0] rdata;
        logic        bus;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] resp;    // response bytes, left aligned
        int          nresp;
    } vec_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       mute = 1'b0;
    logic [7:0] baud_div = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        baudclk16 = 1'b0;
        forever begin
            @(negedge clk);
            baud_div  = baud_div + 8'd1;
            baudclk16 = baud_div[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    // Bus responder: pops expectations when mem_valid appears.
    initial begin
        bus_t        e;
        logic [31:0] a0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_valid && !mute && !reset) begin
                if (exp_bus.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL bus_unexpected: got addr %08h, required no transaction", mem_addr);
                    for (int k = 0; k < 200 && mem_valid; k++) @(negedge clk);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_addr", mem_addr, e.addr);
                    check("bus_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                    if (e.wstrb == 4'hF) check("bus_wdata", mem_wdata, e.wdata);
                    a0 = mem_addr;
                    for (int k = 0; k < e.delay; k++) begin
                        @(negedge clk);
                        check("bus_hold_valid", 32'(mem_valid), 32'd1);
                        check("bus_hold_addr", mem_addr, a0);
                    end
                    mem_ready = 1'b1;
                    mem_rdata = e.rdata;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    mem_rdata = 32'd0;
                    check("bus_valid_drop", 32'(mem_valid), 32'd0);
                end
            end
        end
    end

    // UART response monitor: decodes 8N1 frames at 32 clk per bit.
    initial begin
        logic [7:0] b;
        logic       stp;
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && !reset) begin
                repeat (16) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (32) @(negedge clk);
                    b[i] = txd;
                end
                repeat (32) @(negedge clk);
                stp = txd;
                check("tx_stop", 32'(stp), 32'd1);
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got byte %02h, required none", b);
                end else begin
                    check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (32) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        if (!stop_bit) repeat (64) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_bus.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_valid(output int ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (mem_valid) begin
                ok = 1;
                break;
            end
        end
        check("wait_valid", 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[6];
    int   cnt;
    int   ok;

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        vecs[0] = '{{8'h57, 32'h8000_0000, 32'h0000_0005}, 9, 3, 32'h0, 1'b1,
                    32'h8000_0000, 32'h0000_0005, 4'hF, 32'h4B00_0000, 1};
        vecs[1] = '{{8'h52, 32'h0000_0010, 32'h0}, 5, 0, 32'hDEAD_BEEF, 1'b1,
                    32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 4};
        vecs[2] = '{{8'h52, 32'h0000_0013, 32'h0}, 5, 1, 32'h1234_5678, 1'b1,
                    32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, 4};
        vecs[3] = '{{8'h41, 64'h0}, 1, 0, 32'h0, 1'b0,
                    32'h0, 32'h0, 4'h0, 32'h3F00_0000, 1};
        vecs[4] = '{{8'h57, 32'h1234_567B, 32'hA5C3_0F96}, 9, 1, 32'h0, 1'b1,
                    32'h1234_5678, 32'hA5C3_0F96, 4'hF, 32'h4B00_0000, 1};
        vecs[5] = '{{8'h52, 32'h8000_0004, 32'h0}, 5, 2, 32'h0000_0000, 1'b1,
                    32'h8000_0004, 32'h0, 4'h0, 32'h0000_0000, 4};

        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            if (vecs[r].bus)
                exp_bus.push_back('{vecs[r].addr, vecs[r].wdata, vecs[r].wstrb, vecs[r].delay, vecs[r].rdata});
            for (int j = 0; j < vecs[r].nresp; j++)
                exp_tx.push_back(8'(vecs[r].resp >> (24 - 8 * j)));
            for (int i = 0; i < vecs[r].ncmd; i++)
                send_byte(8'(vecs[r].cmd >> (64 - 8 * i)), 1'b1);
            check("busy_during_cmd", 32'(busy), 32'd1);
            wait_idle("vec_done");
            check("txd_idle", 32'(txd), 32'd1);
        end

        // Framing error on the second address byte aborts the command silently.
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (200) @(negedge clk);
        check("ferr_idle", 32'(busy), 32'd0);
        exp_bus.push_back('{32'h0000_0020, 32'h0, 4'h0, 0, 32'hCAFE_F00D});
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h20, 1'b1);
        wait_idle("after_ferr_done");

        // Responder never answers.
        mute = 1'b1;
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h30, 1'b1);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        exp_tx.push_back(8'h54);
`endif
        wait_valid(ok);
        cnt = ok;
        for (int i = 1; i < 64 && ok != 0; i++) begin
            @(negedge clk);
            if (!mem_valid) break;
            cnt++;
        end
`ifdef UART_BUS_MASTER_TIMEOUT_EN
        check("timeout_valid_cycles", 32'(cnt), 32'd16);
        wait_idle("timeout_done");
`else
        check("no_timeout_valid_held", 32'(cnt), 32'd64);
        pulse_reset();
        repeat (20) @(negedge clk);
`endif

        // Reset in the middle of a bus transaction.
        send_byte(8'h52, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_valid(ok);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(mem_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (mem_valid || busy) cnt++;
        end
        check("midrst_quiet", 32'(cnt), 32'd0);
        mute = 1'b0;
        check("exp_bus_empty", 32'(exp_bus.size()), 32'd0);
        check("exp_tx_empty", 32'(exp_tx.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no completion, required completion");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Debug bridge that receives framed commands on a UART line and issues single-word read/write transactions as an initiator on the valid/ready memory bus, the same bus the peripheral decoder and RAM answer. It gives a host PC direct access to RAM and the 0x8000_00xx peripheral registers without CPU firmware. It sits beside the core on the bus arbitration point and shares the 16x baud tick generator.

## Interface
- TIMEOUT_CYCLES, 1024: maximum clk cycles mem_valid stays high waiting for mem_ready (used only with timeout enabled).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- baudclk16  in  1  one-cycle pulse at 16x baud rate (8N1 framing).
- rxd  in  1  UART receive line, asynchronous, idle high.
- txd  out  1  UART transmit line, idle high.
- mem_valid  out  1  transaction request.
- mem_addr  out  32  word address, bits [1:0] forced 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for write, 4'h0 for read.
- mem_ready  in  1  responder completion, one cycle.
- mem_rdata  in  32  read data, valid while mem_ready high.
- busy  out  1  high from first command byte accepted until last response stop bit sent.

## Operation
- Reset values: txd=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0; parser IDLE; rx/tx idle.
- RX: rxd through 2-flop synchronizer. All sampling on baudclk16 ticks. Low seen in idle starts a frame; low re-checked 8 ticks later (else false start, back to idle); data bits sampled every 16 ticks, LSB first; stop bit sampled 16 ticks after bit 7. Stop=0 is a framing error: byte dropped, parser forced to IDLE.
- TX: start bit, 8 data LSB first, stop bit, 16 ticks each; internal one-byte load strobe, response bytes sent back to back.
- Parser states: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: 0x57 'W' -> ADDR (write); 0x52 'R' -> ADDR (read); any other byte -> RESP sending 0x3F '?'.
  - ADDR: 4 bytes, MSB first, shifted into mem_addr; after 4th: write -> DATA, read -> BUS.
  - DATA: 4 bytes MSB first into mem_wdata; after 4th -> BUS.
  - BUS: mem_valid=1, mem_wstrb set; on mem_valid && mem_ready: capture mem_rdata, -> RESP.
  - RESP: write sends 0x4B 'K'; read sends 4 bytes of captured data MSB first; then IDLE.
- Bytes completing in BUS or RESP are discarded, no error response.
- mem_addr[1:0] always 0 regardless of received bits.

## Timing
- mem_valid rises the clk cycle after the cycle the final command byte's stop bit is accepted.
- mem_addr/mem_wdata/mem_wstrb stable throughout mem_valid high.
- mem_valid falls the cycle after the mem_valid && mem_ready cycle; mem_ready same-cycle as valid assertion is legal (one-cycle transaction).
- First response start bit begins on the first baudclk16 tick after entering RESP.
- busy falls in the cycle the last stop bit's 16th tick completes.
- reset asserted mid-frame or mid-transaction: all outputs to reset values immediately, no bus or UART completion.

## Configuration
- UART_BUS_MASTER_TIMEOUT_EN defined: counter runs in BUS; if mem_ready not seen after TIMEOUT_CYCLES cycles with mem_valid high, mem_valid drops next cycle and RESP sends single byte 0x54 'T' (read or write). Also an inter-byte timeout: in ADDR/DATA, 16*256 baudclk16 ticks without a byte returns to IDLE silently.
- Not defined: BUS waits indefinitely for mem_ready; no inter-byte timeout.

## Test plan
- Write: send 57 80 00 00 00 00 00 00 05, responder ready after 3 cycles -> one transaction addr 0x80000000, wdata 0x00000005, wstrb F; txd returns 0x4B.
- Read: send 52 00 00 00 10, responder returns 0xDEADBEEF with ready in first valid cycle -> wstrb 0, addr 0x10; txd returns DE AD BE EF.
- Unaligned/unknown: send 52 00 00 00 13 -> addr 0x10; send 0x41 -> txd returns 0x3F, no mem_valid.
- Framing error: corrupt stop bit of 2nd address byte -> parser IDLE, no transaction; subsequent valid 'R' command completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): mem_ready never asserted -> mem_valid high exactly 16 cycles, then txd 0x54; macro off -> mem_valid held high.
- Reset mid-transaction: assert reset while mem_valid=1 -> mem_valid, busy 0 and txd 1 same cycle; no response byte after release.
